// File: rtl/xbar_pkg.sv
// xbar_pkg: shared defaults and helpers for the round-robin crossbar.
//   DEF_NUM_PORT / DEF_WIDTH : default port count and flit width
//   PTR_W                    : round-robin pointer width for the default port count
//   ptr_w()                  : pointer width for any port count (never below 1)
package xbar_pkg;
    localparam int DEF_NUM_PORT = 5;
    localparam int DEF_WIDTH    = 64;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W = ptr_w(DEF_NUM_PORT);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, one per crossbar output.
//   req : N-bit request vector, bit i = input i wants this output
//   ptr : index of the highest-priority input this cycle (always < N)
//   gnt : one-hot grant, zero when nothing requests
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter int N  = DEF_NUM_PORT,
    parameter int PW = PTR_W
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic found;

    // Scan N positions starting at ptr, wrapping; the first requester wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int o = 0; o < N; o++) begin
            if (!found && req[(int'(ptr) + o) % N]) begin
                gnt[(int'(ptr) + o) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/xbar_rr_pipe.sv
// xbar_rr_pipe: NUM_PORT x NUM_PORT crossbar with per-output round-robin
// arbitration and a single registered slot per output.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_data      : per-input flit offer, flit i at [i*WIDTH +: WIDTH]
//   alloc                 : per-input one-hot destination row at [i*NUM_PORT +: NUM_PORT]
//   in_ack                : combinational accept, same cycle as the grant
//   out_valid/out_data    : registered output slots
//   out_ready             : downstream consumes slot j this cycle
//   conflict_cnt          : saturating count of well-formed requests left un-acked
//   err_multi             : sticky flag for a valid input with a multi-bit row
module xbar_rr_pipe
    import xbar_pkg::*;
#(
    parameter int NUM_PORT = DEF_NUM_PORT,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_PORT-1:0]          in_valid,
    input  logic [NUM_PORT*WIDTH-1:0]    in_data,
    input  logic [NUM_PORT*NUM_PORT-1:0] alloc,
    output logic [NUM_PORT-1:0]          in_ack,
    output logic [NUM_PORT-1:0]          out_valid,
    output logic [NUM_PORT*WIDTH-1:0]    out_data,
    input  logic [NUM_PORT-1:0]          out_ready,
    output logic [CNT_W-1:0]             conflict_cnt,
    output logic                         err_multi
);
    localparam int PW = ptr_w(NUM_PORT);
    localparam int DW = $clog2(NUM_PORT + 1);

    // row is indexed [input][output]; req and gnt are indexed [output][input]
    logic [NUM_PORT-1:0][NUM_PORT-1:0] row, req, gnt;
    logic [NUM_PORT-1:0]               wf, multi, free, ack;
    logic [NUM_PORT-1:0][PW-1:0]       ptr_q, ptr_d;
    logic [NUM_PORT-1:0][WIDTH-1:0]    data_q, data_d;
    logic [NUM_PORT-1:0]               valid_q, valid_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              err_q, err_d;
    logic [DW-1:0]                     denied;
    logic [CNT_W:0]                    sum;

    always_comb begin
        row   = '0;
        wf    = '0;
        multi = '0;
        free  = '0;
        req   = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            row[i]   = alloc[i*NUM_PORT +: NUM_PORT];
            wf[i]    = in_valid[i] && $onehot(row[i]);
            multi[i] = in_valid[i] && (row[i] != '0) && !$onehot(row[i]);
        end
        for (int j = 0; j < NUM_PORT; j++) begin
            free[j] = !valid_q[j] || out_ready[j];
            for (int i = 0; i < NUM_PORT; i++)
                req[j][i] = wf[i] && row[i][j] && free[j];
        end
    end

    for (genvar j = 0; j < NUM_PORT; j++) begin : g_arb
        rr_arbiter #(.N(NUM_PORT), .PW(PW)) u_arb (
            .req (req[j]),
            .ptr (ptr_q[j]),
            .gnt (gnt[j])
        );
    end

    always_comb begin
        ack     = '0;
        denied  = '0;
        data_d  = data_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        for (int j = 0; j < NUM_PORT; j++) begin
            if (gnt[j] != '0) begin
                valid_d[j] = 1'b1;
                for (int i = 0; i < NUM_PORT; i++) begin
                    if (gnt[j][i]) begin
                        data_d[j] = in_data[i*WIDTH +: WIDTH];
                        ptr_d[j]  = (i == NUM_PORT - 1) ? '0 : PW'(i + 1);
                        ack[i]    = 1'b1;
                    end
                end
            end else if (out_ready[j]) begin
                // Drained with nothing to reload: data is left as-is.
                valid_d[j] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_PORT; i++)
            denied = denied + DW'(wf[i] && !ack[i]);
        // One extra bit catches the carry so the counter clamps instead of wrapping.
        sum   = {1'b0, cnt_q} + (CNT_W + 1)'(denied);
        cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        err_d = err_q || (multi != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_ack       = reset_n ? ack : '0;
    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign conflict_cnt = cnt_q;
    assign err_multi    = err_q;
endmodule

// File: tb/tb_xbar_rr_pipe.sv
// tb_xbar_rr_pipe: directed bench with a per-output expected-flit scoreboard.
module tb_xbar_rr_pipe;
    localparam int NP = 5;
    localparam int W  = 64;
    localparam int CW = 16;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b1;
    logic [NP-1:0]     in_valid;
    logic [NP*W-1:0]   in_data;
    logic [NP*NP-1:0]  alloc;
    logic [NP-1:0]     in_ack;
    logic [NP-1:0]     out_valid;
    logic [NP*W-1:0]   out_data;
    logic [NP-1:0]     out_ready;
    logic [CW-1:0]     conflict_cnt;
    logic              err_multi;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [NP][$];

    always #5 clk = ~clk;

    xbar_rr_pipe #(.NUM_PORT(NP), .WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .alloc        (alloc),
        .in_ack       (in_ack),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .conflict_cnt (conflict_cnt),
        .err_multi    (err_multi)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int i, input int j, input logic [W-1:0] d);
        in_valid[i]          = 1'b1;
        alloc[i*NP +: NP]    = NP'(1) << j;
        in_data[i*W +: W]    = d;
    endtask

    task automatic clr_in();
        in_valid = '0;
        alloc    = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_q();
        for (int j = 0; j < NP; j++) exp_q[j].delete();
    endtask

    task automatic do_reset();
        cyc();
        clr_in();
        reset_n = 1'b0;
        flush_q();
        cyc();
        reset_n = 1'b1;
    endtask

    // Every consumed flit (valid && ready seen mid-cycle) must match the oldest expected one.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset_n) begin
                for (int j = 0; j < NP; j++) begin
                    if (out_valid[j] && out_ready[j]) begin
                        if (exp_q[j].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out%0d: got %h expected none", j, out_data[j*W +: W]);
                        end else begin
                            chk($sformatf("out%0d_data", j), out_data[j*W +: W], exp_q[j].pop_front());
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        in_valid  = '0;
        alloc     = '0;
        in_data   = '0;
        out_ready = '0;
        fork
            monitor();
        join_none

        // Reset state, with a request presented while held in reset
        #2 reset_n = 1'b0;
        set_in(0, 1, 64'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data_nz", W'(out_data != '0), '0);
        chk("rst_ack", W'(in_ack), '0);
        chk("rst_cnt", W'(conflict_cnt), '0);
        chk("rst_err", W'(err_multi), '0);
        clr_in();
        reset_n = 1'b1;

        // Single flit, input 0 -> output 3
        out_ready = '1;
        set_in(0, 3, 64'hA5);
        @(negedge clk);
        chk("t1_ack", W'(in_ack), W'(5'b00001));
        exp_q[3].push_back(64'hA5);
        cyc();
        clr_in();
        chk("t1_valid", W'(out_valid), W'(5'b01000));
        chk("t1_slot3", out_data[3*W +: W], 64'hA5);
        chk("t1_cnt", W'(conflict_cnt), '0);

        // Three inputs contend for output 4; each winner drops out
        do_reset();
        out_ready = '1;
        for (int i = 0; i < 3; i++) set_in(i, 4, 64'h10 + 64'(i));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t2_ack%0d", c), W'(in_ack), W'(NP'(1) << c));
            exp_q[4].push_back(64'h10 + 64'(c));
            cyc();
            in_valid[c] = 1'b0;
            chk($sformatf("t2_valid%0d", c), W'(out_valid), W'(5'b10000));
        end
        clr_in();
        chk("t2_cnt", W'(conflict_cnt), 64'd3);

        // Backpressure on output 2
        do_reset();
        out_ready = 5'b11011;
        set_in(0, 2, 64'h22);
        @(negedge clk);
        chk("t3_load_ack", W'(in_ack), W'(5'b00001));
        exp_q[2].push_back(64'h22);
        cyc();
        clr_in();
        set_in(1, 2, 64'h33);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("t3_ack%0d", c), W'(in_ack), '0);
            chk($sformatf("t3_hold%0d", c), out_data[2*W +: W], 64'h22);
            cyc();
        end
        chk("t3_cnt", W'(conflict_cnt), 64'd4);
        chk("t3_valid", W'(out_valid), W'(5'b00100));
        out_ready = '1;
        @(negedge clk);
        chk("t3_release_ack", W'(in_ack), W'(5'b00010));
        exp_q[2].push_back(64'h33);
        cyc();
        clr_in();
        chk("t3_cnt_after", W'(conflict_cnt), 64'd4);
        chk("t3_reload", out_data[2*W +: W], 64'h33);

        // Multi-bit row, zero row, sticky error
        in_valid[3]       = 1'b1;
        alloc[3*NP +: NP] = 5'b00110;
        in_data[3*W +: W] = 64'hBAD;
        @(negedge clk);
        chk("t4_multi_ack", W'(in_ack), '0);
        cyc();
        clr_in();
        chk("t4_err", W'(err_multi), 64'd1);
        chk("t4_cnt", W'(conflict_cnt), 64'd4);
        in_valid[4] = 1'b1;
        @(negedge clk);
        chk("t4_zero_ack", W'(in_ack), '0);
        cyc();
        clr_in();
        chk("t4_zero_cnt", W'(conflict_cnt), 64'd4);
        set_in(4, 0, 64'h44);
        @(negedge clk);
        chk("t4_ok_ack", W'(in_ack), W'(5'b10000));
        exp_q[0].push_back(64'h44);
        cyc();
        clr_in();
        repeat (3) cyc();
        chk("t4_err_held", W'(err_multi), 64'd1);
        do_reset();
        chk("t4_err_cleared", W'(err_multi), '0);

        // Counter saturation: 13106 cycles of 5 denials, then 4 -> 0xFFFE, then 3 -> clamp
        out_ready = '0;
        set_in(0, 0, 64'h77);
        @(negedge clk);
        chk("t5_load_ack", W'(in_ack), W'(5'b00001));
        exp_q[0].push_back(64'h77);
        cyc();
        for (int i = 0; i < NP; i++) set_in(i, 0, 64'h80 + 64'(i));
        @(negedge clk);
        chk("t5_block_ack", W'(in_ack), '0);
        repeat (13106) @(posedge clk);
        #1;
        chk("t5_cnt_mid", W'(conflict_cnt), 64'd65530);
        in_valid[4] = 1'b0;
        cyc();
        chk("t5_cnt_fffe", W'(conflict_cnt), 64'hFFFE);
        in_valid[3] = 1'b0;
        cyc();
        chk("t5_cnt_sat", W'(conflict_cnt), 64'hFFFF);
        in_valid = '1;
        cyc();
        chk("t5_cnt_stay", W'(conflict_cnt), 64'hFFFF);
        clr_in();
        out_ready = '1;
        cyc();
        chk("t5_drained", W'(out_valid), '0);
        chk("t5_data_kept", out_data[0*W +: W], 64'h77);

        // Asynchronous reset with all slots full; pointers restart at 0
        do_reset();
        out_ready = '0;
        for (int i = 0; i < NP; i++) set_in(i, i, 64'hC0 + 64'(i));
        @(negedge clk);
        chk("t6_fill_ack", W'(in_ack), W'(5'b11111));
        for (int i = 0; i < NP; i++) exp_q[i].push_back(64'hC0 + 64'(i));
        cyc();
        clr_in();
        chk("t6_full", W'(out_valid), W'(5'b11111));
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_clear", W'(out_valid), '0);
        flush_q();
        set_in(0, 1, 64'hEE);
        #1;
        chk("t6_ack_in_reset", W'(in_ack), '0);
        clr_in();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = '1;
        for (int i = 0; i < NP; i++) set_in(i, 1, 64'hD0 + 64'(i));
        @(negedge clk);
        chk("t6_first_grant", W'(in_ack), W'(5'b00001));
        exp_q[1].push_back(64'hD0);
        cyc();
        clr_in();
        chk("t6_cnt", W'(conflict_cnt), 64'd4);
        repeat (2) cyc();

        for (int j = 0; j < NP; j++)
            chk($sformatf("q%0d_empty", j), W'(exp_q[j].size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xbar_rr_pipe.md
XBAR_RR_PIPE -- requirements
Module: xbar_rr_pipe

Interface
REQ-001 Parameter NUM_PORT, default 5, number of input ports and number of output ports (2..16).
REQ-002 Parameter WIDTH, default 64, flit width in bits.
REQ-003 Parameter CNT_W, default 16, width of the conflict counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  NUM_PORT  bit i = input i presents a flit.
REQ-007 in_data  input  NUM_PORT*WIDTH  flit i at [i*WIDTH +: WIDTH].
REQ-008 alloc  input  NUM_PORT*NUM_PORT  row i at [i*NUM_PORT +: NUM_PORT]; one-hot requested output for input i.
REQ-009 in_ack  output  NUM_PORT  bit i = flit i accepted this cycle; combinational.
REQ-010 out_valid  output  NUM_PORT  bit j = out_data slot j holds a flit.
REQ-011 out_data  output  NUM_PORT*WIDTH  registered flit j at [j*WIDTH +: WIDTH].
REQ-012 out_ready  input  NUM_PORT  bit j = downstream consumes slot j this cycle.
REQ-013 conflict_cnt  output  CNT_W  saturating count of requests denied by arbitration or backpressure.
REQ-014 err_multi  output  1  sticky flag: a valid input presented a row with more than one bit set.

Function
REQ-015 Slot j free = !out_valid[j] || out_ready[j].
REQ-016 Input i requests output j when in_valid[i], alloc row i is one-hot, and row i bit j is set.
REQ-017 Zero rows are ignored: no ack, no count, no error.
REQ-018 Multi-bit rows are never granted, set err_multi, and are not counted in conflict_cnt.
REQ-019 Per output j, when the slot is free, one requester is granted by round-robin starting at pointer rr_ptr[j].
REQ-020 On grant to input k, rr_ptr[j] <= (k+1) mod NUM_PORT. With no grant, rr_ptr[j] holds.
REQ-021 in_ack[i] is high in the same cycle as the grant. Granted in_data is registered into slot j, and out_valid[j] = 1 on the next edge (latency 1).
REQ-022 Slot free, out_ready[j]=1 and a new grant in the same cycle: slot reloads and out_valid[j] stays 1, so back-to-back throughput is 1 flit/cycle/output.
REQ-023 out_ready[j]=1 with no grant: out_valid[j] <= 0 and out_data holds its value.
REQ-024 Slot not free (valid and !ready): no grant, and slot contents and valid hold.
REQ-025 Each cycle, conflict_cnt increments by the number of well-formed requests not acked. It saturates at all-ones and never wraps.
REQ-026 An un-acked input receives no retry state; the sender re-presents the flit on a later cycle.
REQ-027 At most one in_ack per input per cycle, and at most one grant per output per cycle.

Reset
REQ-028 reset_n low asynchronously clears: out_valid = 0, out_data = 0, rr_ptr = 0, conflict_cnt = 0, err_multi = 0.
REQ-029 in_ack is 0 while reset_n is low.
REQ-030 Reset mid-operation drops all buffered flits without any ack or count side effect.
REQ-031 err_multi is cleared only by reset.

Structure
REQ-032 Shared package xbar_pkg holds the NUM_PORT and WIDTH defaults and the pointer width constant PTR_W = clog2(NUM_PORT).
REQ-033 Sub-module rr_arbiter (NUM_PORT-bit request, pointer in, one-hot grant out) is instantiated once per output.
REQ-034 Output slots and counters live in xbar_rr_pipe. No other sub-modules.

Verification
REQ-035 Reset, then input 0 sends 0xA5 to output 3 with out_ready=all ones -> in_ack=00001, and next cycle out_valid=01000 with slot 3 = 0xA5.
REQ-036 Inputs 0, 1 and 2 all target output 4 for 3 consecutive cycles, out_ready=1 -> acks go to 0, then 1, then 2; conflict_cnt reads 2+1+0 = 3.
REQ-037 Slot 2 valid with out_ready[2]=0 for 4 cycles while input 1 targets output 2 -> in_ack[1]=0 every cycle, slot 2 data unchanged, conflict_cnt=4.
REQ-038 Input 3 with row 00110 and in_valid=1 -> no ack, err_multi=1 and held until reset, conflict_cnt unchanged.
REQ-039 Force conflict_cnt to 0xFFFE, then generate 3 denials -> reads 0xFFFF and stays there.
REQ-040 Assert reset_n low while out_valid=11111 -> out_valid=0 immediately (asynchronous), and after release the first grant per output goes to the lowest-index requester.
